// File: rtl/i2c_segment_target.sv
// I2C target front end for the 7-segment output stage.
// Decodes START/STOP on a synchronized SCL/SDA pair, matches a 7-bit address,
// ACKs written bytes into seg_data and returns seg_data on reads.
// SDA is open-drain: the block only ever pulls low via sda_oe.
//
// Ports:
//   clk        system clock (>= 10x SCL)
//   rst_n      asynchronous active-low reset
//   ena        design enable; low holds the block idle (seg_data kept)
//   scl_in     raw SCL pin (asynchronous)
//   sda_in     raw SDA pin (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   seg_data   segment register
//   seg_valid  one-clk pulse when a write updates seg_data
//   busy       high while an addressed transaction is in progress
module i2c_segment_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h3C,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] seg_data,
  output logic       seg_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StIgnore
  } state_e;

  // Synchronizers plus one history flop each for edge detection.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_drv_q, ack_drv_d;   // ACK phase: SDA already pulled low
  logic       rw_q, rw_d;
  logic       rd_first_q, rd_first_d; // READ entered with bit 7 not yet driven
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] seg_data_q, seg_data_d;
  logic       seg_valid_q, seg_valid_d;

  logic scl_s, sda_s;
  logic start_ev, stop_ev, scl_rise, scl_fall;

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign start_ev = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_ev  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ack_drv_q   <= 1'b0;
      rw_q        <= 1'b0;
      rd_first_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      seg_data_q  <= RESET_VALUE;
      seg_valid_q <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], scl_in};
      sda_sync_q  <= {sda_sync_q[0], sda_in};
      scl_hist_q  <= scl_sync_q[1];
      sda_hist_q  <= sda_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_drv_q   <= ack_drv_d;
      rw_q        <= rw_d;
      rd_first_q  <= rd_first_d;
      sda_oe_q    <= sda_oe_d;
      seg_data_q  <= seg_data_d;
      seg_valid_q <= seg_valid_d;
    end
  end

  // Next-state logic; bus conditions take precedence over SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_drv_d   = ack_drv_q;
    rw_d        = rw_q;
    rd_first_d  = rd_first_q;
    sda_oe_d    = sda_oe_q;
    seg_data_d  = seg_data_q;
    seg_valid_d = 1'b0;

    if (!ena) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (stop_ev) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_ev) begin
      state_d   = StAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // shift_q[6:0] holds the address, the current bit is R/W
              rw_d      = sda_s;
              bit_cnt_d = 3'd0;
              ack_drv_d = 1'b0;
              state_d   = (shift_q[6:0] == I2C_ADDR) ? StAddrAck : StIgnore;
            end
          end
        end
        StAddrAck, StWriteAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sda_oe_d  = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                // Release of the ACK coincides with driving read bit 7
                state_d    = StRead;
                shift_d    = seg_data_q;
                sda_oe_d   = ~seg_data_q[7];
                rd_first_d = 1'b0;
              end else begin
                state_d  = StWrite;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        StWrite: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              seg_data_d  = {shift_q[6:0], sda_s};
              seg_valid_d = 1'b1;
              bit_cnt_d   = 3'd0;
              ack_drv_d   = 1'b0;
              state_d     = StWriteAck;
            end
          end
        end
        StRead: begin
          if (scl_fall) begin
            if (rd_first_q) begin
              rd_first_d = 1'b0;
              sda_oe_d   = ~shift_q[7];
            end else if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = StReadAck;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StReadAck: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_d    = StRead;
              shift_d    = seg_data_q;
              rd_first_d = 1'b1;
              bit_cnt_d  = 3'd0;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default:  state_d  = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    sda_oe    = sda_oe_q;
    seg_data  = seg_data_q;
    seg_valid = seg_valid_q;
    busy      = (state_q == StAddrAck) || (state_q == StWrite) || (state_q == StWriteAck) ||
                (state_q == StRead) || (state_q == StReadAck);
  end

endmodule

// File: tb/tb_i2c_segment_target.sv
`timescale 1ns/1ps
module tb_i2c_segment_target;

  localparam logic [6:0] ADDR    = 7'h3C;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam int Q = 8;   // clk cycles of SCL-low half-phases
  localparam int H = 16;  // clk cycles of SCL high

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, seg_valid, busy;
  logic [7:0] seg_data;

  assign sda_line = sda_m & ~sda_oe;

  i2c_segment_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .seg_data  (seg_data),
    .seg_valid (seg_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must be once the bus has settled.
  logic [7:0] exp_seg = RST_VAL;
  logic       exp_busy = 1'b0;
  logic       exp_oe = 1'b0;
  logic       oe_skip = 1'b0;  // after an SCL fall, until the next bit's expectation
  int         exp_vcnt = 0;
  int         valid_cnt = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         checks = 0;
  int         passes = 0;
  logic [7:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && seg_valid) valid_cnt <= valid_cnt + 1;

  // Per-cycle compare once the synchronizer latency after a pin change has elapsed.
  always @(negedge clk) begin
    if (rst_n && (cyc - last_chg >= 5)) begin
      check("seg_data", {24'd0, seg_data}, {24'd0, exp_seg});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("seg_valid", {31'd0, seg_valid}, 32'd0);
      if (!oe_skip) check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
    end
  end

  task automatic pins(input logic scl, input logic sda, input int n);
    scl_m    = scl;
    sda_m    = sda;
    last_chg = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL clock. e_oe applies from the start of the bit; e_busy/e_seg from SCL rise.
  task automatic bit_t(input logic m, input logic e_oe, input logic e_busy,
                       input logic [7:0] e_seg, output logic line);
    exp_oe  = e_oe;
    oe_skip = 1'b0;
    pins(1'b0, m, Q);
    exp_busy = e_busy;
    exp_seg  = e_seg;
    pins(1'b1, m, H);
    line    = sda_line;
    oe_skip = 1'b1;
    pins(1'b0, m, Q);
  endtask

  task automatic start_cond();
    exp_oe  = 1'b0;
    oe_skip = 1'b0;
    pins(1'b0, 1'b1, Q);
    pins(1'b1, 1'b1, Q);
    exp_busy = 1'b0;
    pins(1'b1, 1'b0, Q);
    pins(1'b0, 1'b0, Q);
  endtask

  task automatic stop_cond();
    exp_oe  = 1'b0;
    oe_skip = 1'b0;
    pins(1'b0, 1'b0, Q);
    pins(1'b1, 1'b0, Q);
    exp_busy = 1'b0;
    pins(1'b1, 1'b1, Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic ack_exp, input logic busy_after,
                         input logic [7:0] seg_after, output logic acked);
    logic l;
    for (int i = 7; i >= 0; i--)
      bit_t(b[i], 1'b0, (i == 0) ? busy_after : exp_busy, (i == 0) ? seg_after : exp_seg, l);
    bit_t(1'b1, ack_exp, exp_busy, exp_seg, l);
    acked = ~l;
  endtask

  task automatic write_txn(input logic [7:0] ab, input logic [7:0] d0, input logic [7:0] d1,
                           input int n);
    logic hit, ack;
    logic [7:0] d;
    hit = ena && (ab[7:1] == ADDR) && !ab[0];
    start_cond();
    wr_byte(ab, hit, hit, exp_seg, ack);
    check("addr_ack", {31'd0, ack}, {31'd0, hit});
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      wr_byte(d, hit, hit, hit ? d : exp_seg, ack);
      check("data_ack", {31'd0, ack}, {31'd0, hit});
      if (hit) exp_vcnt++;
    end
    stop_cond();
    check("valid_cnt", valid_cnt, exp_vcnt);
  endtask

  // Master ACKs every byte but the last.
  task automatic read_txn(input int n);
    logic ack, l, last;
    logic [7:0] rd;
    start_cond();
    wr_byte({ADDR, 1'b1}, 1'b1, 1'b1, exp_seg, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        bit_t(1'b1, ~exp_seg[i], exp_busy, exp_seg, l);
        rd[i] = l;
      end
      last = (k == n - 1);
      bit_t(last, 1'b0, last ? 1'b0 : exp_busy, exp_seg, l);
      check("read_byte", {24'd0, rd}, {24'd0, exp_seg});
      last_rd = rd;
    end
    stop_cond();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic ack, l;
    logic [7:0] nib;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    check("rst_seg", {24'd0, seg_data}, {24'd0, RST_VAL});
    check("rst_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, seg_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pins(1'b1, 1'b1, Q);

    // Addressed write
    write_txn(8'h78, 8'h5A, 8'h00, 1);
    check("lit_seg_5a", {24'd0, seg_data}, 32'h5A);
    check("lit_vcnt_1", valid_cnt, 1);

    // Wrong address: ignored
    write_txn(8'h42, 8'hFF, 8'h00, 1);
    check("lit_seg_kept", {24'd0, seg_data}, 32'h5A);

    // Two-byte write
    write_txn(8'h78, 8'h11, 8'h22, 2);
    check("lit_seg_22", {24'd0, seg_data}, 32'h22);
    check("lit_vcnt_3", valid_cnt, 3);

    // Read back twice
    read_txn(2);
    check("lit_read_22", {24'd0, last_rd}, 32'h22);

    // Abort after 4 bits of 0xC3
    nib = 8'hC3;
    start_cond();
    wr_byte(8'h78, 1'b1, 1'b1, exp_seg, ack);
    check("abort_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 7; i >= 4; i--) bit_t(nib[i], 1'b0, exp_busy, exp_seg, l);
    stop_cond();
    check("abort_vcnt", valid_cnt, exp_vcnt);

    // Repeated START mid-byte, then a new addressed write
    start_cond();
    wr_byte(8'h78, 1'b1, 1'b1, exp_seg, ack);
    for (int i = 7; i >= 4; i--) bit_t(nib[i], 1'b0, exp_busy, exp_seg, l);
    start_cond();
    wr_byte(8'h78, 1'b1, 1'b1, exp_seg, ack);
    check("rs_addr_ack", {31'd0, ack}, 32'd1);
    wr_byte(8'h99, 1'b1, 1'b1, 8'h99, ack);
    exp_vcnt++;
    check("rs_data_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    check("lit_seg_99", {24'd0, seg_data}, 32'h99);
    check("rs_vcnt", valid_cnt, exp_vcnt);

    // Disabled block ignores the bus
    ena = 1'b0;
    write_txn(8'h78, 8'h01, 8'h00, 1);
    ena = 1'b1;
    check("lit_ena_kept", {24'd0, seg_data}, 32'h99);

    // Reset during WRITE_ACK while SDA is pulled low
    start_cond();
    wr_byte(8'h78, 1'b1, 1'b1, exp_seg, ack);
    for (int i = 7; i >= 1; i--) bit_t(nib[i], 1'b0, exp_busy, exp_seg, l);
    bit_t(nib[0], 1'b0, 1'b1, 8'hC3, l);
    exp_vcnt++;
    exp_oe  = 1'b1;
    oe_skip = 1'b0;
    pins(1'b0, 1'b1, Q);
    pins(1'b1, 1'b1, 4);
    check("pre_rst_oe", {31'd0, sda_oe}, 32'd1);
    check("pre_rst_seg", {24'd0, seg_data}, 32'hC3);
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", {31'd0, sda_oe}, 32'd0);
    check("async_rst_seg", {24'd0, seg_data}, {24'd0, RST_VAL});
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_seg  = RST_VAL;
    exp_busy = 1'b0;
    exp_oe   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pins(1'b1, 1'b1, Q);

    write_txn(8'h78, 8'hE7, 8'h00, 1);
    check("lit_seg_e7", {24'd0, seg_data}, 32'hE7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
